// File: rtl/mxv_pkg.sv
// ---------------------------------------------------------------------------
// mxv_pkg
// Shared definitions for the matrix-vector engine and its UART neighbours.
//   WORD_LENGTH : width of one matrix/vector element
//   MAX_N       : largest supported matrix dimension
//   ACC_WIDTH   : dot-product width; wide enough for MAX_N full-scale products
//   mxv_state_t : engine FSM states
// ---------------------------------------------------------------------------
package mxv_pkg;

  localparam int WORD_LENGTH = 8;
  localparam int MAX_N       = 8;
  localparam int ACC_WIDTH   = 2 * WORD_LENGTH + $clog2(MAX_N);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    MAC,
    EMIT,
    DONE
  } mxv_state_t;

endpackage

// File: rtl/mxv_mac.sv
// ---------------------------------------------------------------------------
// mxv_mac
// Unsigned multiply-accumulate register.
//   clk      in  : clock, rising edge
//   reset    in  : synchronous, active-low reset (clears the accumulator)
//   i_clear  in  : clear accumulator (wins over i_en)
//   i_en     in  : accumulate i_a * i_b this cycle
//   i_a, i_b in  : unsigned operands, IN_WIDTH bits each
//   o_acc    out : registered accumulator, ACC_WIDTH bits
// ---------------------------------------------------------------------------
module mxv_mac #(
  parameter int IN_WIDTH  = mxv_pkg::WORD_LENGTH,
  parameter int ACC_WIDTH = mxv_pkg::ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [IN_WIDTH-1:0]  i_a,
  input  logic [IN_WIDTH-1:0]  i_b,
  output logic [ACC_WIDTH-1:0] o_acc
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_prod;

  // Operands are widened first so the product is formed at full accumulator width.
  assign w_prod = ACC_WIDTH'(i_a) * ACC_WIDTH'(i_b);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mxv_engine.sv
// ---------------------------------------------------------------------------
// mxv_engine
// Pops an N x N matrix (row-major, one byte per pop) from the receive FIFO,
// forms the dot product of each row with a vector latched at job start and
// hands each row result downstream over valid/ready.
//   clk, reset          : clock / synchronous active-low reset
//   start, matrix_length: job request and its dimension N (1..MAX_N accepted)
//   vector              : element c at [c*WORD_LENGTH +: WORD_LENGTH]
//   fifo_empty/data/pop : receive FIFO; data valid the cycle after a pop
//   result_data/index   : row dot product and its row number
//   result_valid/ready  : result handshake
//   busy, done          : job in flight / one-cycle completion pulse
//   length_error        : one-cycle pulse when a start carries an illegal N
// ---------------------------------------------------------------------------
module mxv_engine #(
  parameter int WORD_LENGTH = mxv_pkg::WORD_LENGTH,
  parameter int MAX_N       = mxv_pkg::MAX_N,
  parameter int ACC_WIDTH   = 2 * WORD_LENGTH + $clog2(MAX_N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WORD_LENGTH-1:0]       matrix_length,
  input  logic [MAX_N*WORD_LENGTH-1:0] vector,
  input  logic                         fifo_empty,
  input  logic [WORD_LENGTH-1:0]       fifo_data,
  output logic                         fifo_pop,
  output logic [ACC_WIDTH-1:0]         result_data,
  output logic [WORD_LENGTH-1:0]       result_index,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         length_error
);

  import mxv_pkg::*;

  localparam logic [WORD_LENGTH-1:0] ONE = WORD_LENGTH'(1);

  mxv_state_t r_state;
  mxv_state_t w_state_next;

  logic [WORD_LENGTH-1:0]       r_n;
  logic [WORD_LENGTH-1:0]       r_row;
  logic [WORD_LENGTH-1:0]       r_col;
  logic [MAX_N*WORD_LENGTH-1:0] r_vector;
  logic                         r_length_error;

  logic [WORD_LENGTH-1:0] w_vec_elem;
  logic [ACC_WIDTH-1:0]   w_acc;
  logic w_len_ok;
  logic w_job_start;
  logic w_col_last;
  logic w_row_last;
  logic w_accept;
  logic w_pop;
  logic w_mac_clear;
  logic w_mac_en;

  assign w_len_ok    = (matrix_length != '0) && (32'(matrix_length) <= MAX_N);
  assign w_job_start = (r_state == IDLE) && start && w_len_ok;
  assign w_col_last  = (r_col == r_n - ONE);
  assign w_row_last  = (r_row == r_n - ONE);
  assign w_accept    = (r_state == EMIT) && result_ready;

  // Column c of the latched vector; r_col never exceeds N-1 <= MAX_N-1.
  assign w_vec_elem = r_vector[32'(r_col) * WORD_LENGTH +: WORD_LENGTH];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state and controls ----------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_mac_clear  = 1'b0;
    w_mac_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_job_start) begin
          w_mac_clear  = 1'b1;
          w_state_next = POP;
        end
      end
      POP: begin
        // Pop is gated by fifo_empty combinationally so it can never underflow.
        if (!fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = MAC;
        end
      end
      MAC: begin
        w_mac_en     = 1'b1;
        w_state_next = w_col_last ? EMIT : POP;
      end
      EMIT: begin
        if (result_ready) begin
          if (w_row_last) begin
            w_state_next = DONE;
          end else begin
            w_mac_clear  = 1'b1;
            w_state_next = POP;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------- Job context and counters ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_n            <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_vector       <= '0;
      r_length_error <= 1'b0;
    end else begin
      r_length_error <= (r_state == IDLE) && start && !w_len_ok;
      if (w_job_start) begin
        r_n      <= matrix_length;
        r_vector <= vector;
        r_row    <= '0;
        r_col    <= '0;
      end else if (r_state == MAC && !w_col_last) begin
        r_col <= r_col + ONE;
      end else if (w_accept && !w_row_last) begin
        r_row <= r_row + ONE;
        r_col <= '0;
      end
    end
  end

  mxv_mac #(
    .IN_WIDTH  (WORD_LENGTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_mac_clear),
    .i_en    (w_mac_en),
    .i_a     (fifo_data),
    .i_b     (w_vec_elem),
    .o_acc   (w_acc)
  );

  assign fifo_pop     = w_pop;
  assign result_data  = w_acc;
  assign result_index = r_row;
  assign result_valid = (r_state == EMIT);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign length_error = r_length_error;

endmodule

// File: tb/tb_mxv_engine.sv
// ---------------------------------------------------------------------------
// tb_mxv_engine
// Drives mxv_engine through directed and randomized jobs. A small FIFO model
// feeds matrix bytes; expected row results come from plain dot-product sums.
// ---------------------------------------------------------------------------
module tb_mxv_engine;

  localparam int WL   = 8;
  localparam int MAXN = 8;
  localparam int AW   = 2 * WL + $clog2(MAXN);

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [WL-1:0]       matrix_length = '0;
  logic [MAXN*WL-1:0]  vector = '0;
  logic                fifo_empty;
  logic [WL-1:0]       fifo_data = '0;
  logic                fifo_pop;
  logic [AW-1:0]       result_data;
  logic [WL-1:0]       result_index;
  logic                result_valid;
  logic                result_ready = 1'b0;
  logic                busy;
  logic                done;
  logic                length_error;

  always #5 clk = ~clk;

  mxv_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .matrix_length (matrix_length),
    .vector        (vector),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_pop      (fifo_pop),
    .result_data   (result_data),
    .result_index  (result_index),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .done          (done),
    .length_error  (length_error)
  );

  // ---------------- receive FIFO model ----------------
  logic [WL-1:0] fifo_mem [0:1023];
  int   fifo_wr = 0;
  int   fifo_rd = 0;
  int   pop_err = 0;
  logic stall = 1'b0;

  assign fifo_empty = stall || (fifo_rd == fifo_wr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (fifo_empty) begin
        pop_err <= pop_err + 1;
      end else begin
        fifo_data <= fifo_mem[fifo_rd[9:0]];
        fifo_rd   <= fifo_rd + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_pop"},    fifo_pop,     0);
    check_value({tag, "_data"},   result_data,  0);
    check_value({tag, "_index"},  result_index, 0);
    check_value({tag, "_valid"},  result_valid, 0);
    check_value({tag, "_busy"},   busy,         0);
    check_value({tag, "_done"},   done,         0);
    check_value({tag, "_lenerr"}, length_error, 0);
  endtask

  // ---------------- job stimulus and reference ----------------
  logic [WL-1:0] mat [0:MAXN*MAXN-1];
  logic [WL-1:0] vec [0:MAXN-1];
  longint        exp_res [0:MAXN-1];

  // ready_mode: 0 = always ready, 1 = random ready, 2 = hold off 4 cycles on row 0
  // abort_at  : >0 asserts reset once that many elements have been popped
  task automatic run_job(input int n, input int ready_mode, input int stall_at,
                         input int stall_len, input int abort_at);
    int  base;
    int  pops;
    int  accepted;
    int  done_cnt;
    int  last_acc_cyc;
    int  stall_cnt;
    int  zero_ready_left;
    bit  finished;
    bit  aborted;
    bit  hold_pend;
    logic [AW-1:0] hold_data;
    logic [WL-1:0] hold_idx;

    accepted = 0; done_cnt = 0; last_acc_cyc = -10; stall_cnt = 0;
    finished = 0; aborted = 0; hold_pend = 0; hold_data = '0; hold_idx = '0;
    zero_ready_left = (ready_mode == 2) ? 4 : 0;

    for (int r = 0; r < n; r++) begin
      exp_res[r] = 0;
      for (int c = 0; c < n; c++) exp_res[r] += longint'(mat[r*n+c]) * longint'(vec[c]);
    end
    for (int i = 0; i < n*n; i++) begin
      fifo_mem[fifo_wr[9:0]] = mat[i];
      fifo_wr++;
    end
    base = fifo_rd;

    @(negedge clk);
    start = 1'b1;
    matrix_length = WL'(n);
    for (int c = 0; c < MAXN; c++) vector[c*WL +: WL] = (c < n) ? vec[c] : WL'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    vector = {$urandom, $urandom};  // engine must use its latched copy

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      pops = fifo_rd - base;
      if (abort_at > 0 && pops == abort_at) begin
        reset = 1'b0;
        aborted = 1;
        finished = 1;
      end else begin
        if (stall_len > 0 && pops == stall_at && stall_cnt < stall_len) begin
          stall = 1'b1;
          stall_cnt++;
        end else begin
          stall = 1'b0;
        end
        if (ready_mode == 0) result_ready = 1'b1;
        else if (ready_mode == 1) result_ready = 1'($urandom_range(0, 1));
        else if (result_valid && zero_ready_left > 0) begin
          result_ready = 1'b0;
          zero_ready_left--;
        end else result_ready = 1'b1;
        #1;
        if (cyc == 0 && (stall_len == 0 || stall_at != 0)) check_value("first_pop", fifo_pop, 1);
        if (stall) check_value("stall_no_pop", fifo_pop, 0);
        if (hold_pend) begin
          check_value("hold_valid", result_valid, 1);
          check_value("hold_data",  result_data,  hold_data);
          check_value("hold_index", result_index, hold_idx);
        end
        hold_pend = 0;
        if (done) begin
          done_cnt++;
          check_value("done_after_last", cyc, last_acc_cyc + 1);
          finished = 1;
        end else begin
          check_value("busy", busy, 1);
          if (result_valid) begin
            if (accepted < n) begin
              check_value("row_index", result_index, accepted);
              check_value("row_data",  result_data,  exp_res[accepted]);
            end else begin
              check_value("extra_row", accepted, n - 1);
            end
            if (result_ready) begin
              accepted++;
              last_acc_cyc = cyc;
            end else begin
              hold_pend = 1;
              hold_data = result_data;
              hold_idx  = result_index;
            end
          end
          check_value("pop_window", (pops <= (accepted + 1) * n), 1);
        end
      end
    end
    stall = 1'b0;

    if (!finished) check_value("timeout", 0, 1);
    if (!aborted) begin
      check_value("rows_out",  accepted, n);
      check_value("pop_count", fifo_rd - base, n * n);
      check_value("done_count", done_cnt, 1);
      check_value("pop_while_empty", pop_err, 0);
      @(negedge clk);
      check_value("post_busy", busy, 0);
      check_value("post_done", done, 0);
      $display("job n=%0d ready_mode=%0d rows=%0d pops=%0d", n, ready_mode, accepted, fifo_rd - base);
    end else begin
      $display("job n=%0d aborted by reset after %0d pops", n, fifo_rd - base);
    end
  endtask

  task automatic try_bad_length(input logic [WL-1:0] len);
    int p0;
    fifo_mem[fifo_wr[9:0]] = 8'h5A;
    fifo_wr++;
    p0 = fifo_rd;
    @(negedge clk);
    start = 1'b1;
    matrix_length = len;
    @(negedge clk);
    start = 1'b0;
    check_value("lenerr_pulse", length_error, 1);
    check_value("lenerr_busy",  busy, 0);
    @(negedge clk);
    check_value("lenerr_clear", length_error, 0);
    check_value("lenerr_idle",  busy, 0);
    check_value("lenerr_pops",  fifo_rd - p0, 0);
    fifo_wr = fifo_rd;
    $display("bad length %0d rejected", len);
  endtask

  task automatic rand_job_data(input int n);
    for (int i = 0; i < n*n; i++) mat[i] = WL'($urandom);
    for (int c = 0; c < n; c++) vec[c] = WL'($urandom);
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // small directed job
    mat[0] = 8'd1; mat[1] = 8'd2; mat[2] = 8'd3; mat[3] = 8'd4;
    vec[0] = 8'd5; vec[1] = 8'd6;
    run_job(2, 0, 0, 0, 0);

    // full-scale job at the largest size
    for (int i = 0; i < MAXN*MAXN; i++) mat[i] = 8'hFF;
    for (int c = 0; c < MAXN; c++) vec[c] = 8'hFF;
    run_job(8, 0, 0, 0, 0);

    // FIFO runs dry for 5 cycles before the third element
    mat[0] = 8'd1; mat[1] = 8'd2; mat[2] = 8'd3; mat[3] = 8'd4;
    vec[0] = 8'd5; vec[1] = 8'd6;
    run_job(2, 0, 2, 5, 0);

    // downstream holds off row 0 for 4 cycles
    run_job(2, 2, 0, 0, 0);

    // illegal dimensions
    try_bad_length(8'd0);
    try_bad_length(8'd9);

    // reset during the MAC of row 1, then a fresh one-element job
    rand_job_data(2);
    run_job(2, 0, 0, 0, 3);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    fifo_wr = fifo_rd;
    mat[0] = 8'd7; vec[0] = 8'd3;
    run_job(1, 0, 0, 0, 0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, MAXN);
      rand_job_data(n);
      run_job(n, 1, $urandom_range(0, n*n - 1), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
